// File: rtl/aoi_pkg.sv
// Shared types and the per-lane combine/invert function for the AOI pipeline.
package aoi_pkg;

   // Function select: bit 0 picks the reduction/combine pair, bit 1 suppresses the invert.
   typedef enum logic [1:0] {
      AOI = 2'b00,
      OAI = 2'b01,
      AO  = 2'b10,
      OA  = 2'b11
   } aoi_mode_e;

   // Widest lane vector aoi_eval handles; callers zero-extend and truncate to their N.
   localparam int AOI_MAX_W = 64;

   // Combine the reduced operand t with d, then optionally invert.
   // AND/OR reductions pair with OR/AND combines respectively.
   function automatic logic [AOI_MAX_W-1:0] aoi_eval(input logic [AOI_MAX_W-1:0] t,
                                                     input logic [AOI_MAX_W-1:0] d,
                                                     input aoi_mode_e            mode);
      logic [AOI_MAX_W-1:0] c;
      c = mode[0] ? (t & d) : (t | d);
      return mode[1] ? c : ~c;
   endfunction

endpackage

// File: rtl/aoi_stage.sv
// One valid/ready register slice. Accepts when empty or when its content leaves
// in the same cycle, so back-to-back transfers run at full rate.
module aoi_stage #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   output logic         ready_o,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   input  logic         ready_i
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         load;

   // Next-state: load on handshake; valid clears only if drained and not reloaded.
   always_comb begin
      ready_o = !valid_q || ready_i;
      load    = valid_i && ready_o;
      valid_d = load || (valid_q && !ready_i);
      data_d  = load ? data_i : data_q;
   end

   // Slice registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/aoi_pipe.sv
// Two-stage pipelined AND-OR-INVERT family with flow control and a saturating
// count of delivered all-zero results.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The sender keeps valid and data stable until that transfer; ready may
// depend combinationally on the downstream ready but never on valid.
module aoi_pipe
   import aoi_pkg::*;
#(
   parameter int N  = 2,
   parameter int M  = 3,
   parameter int CW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [M*N-1:0] ops,
   input  logic [N-1:0]   d,
   input  logic [1:0]     mode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   y,
   output logic [CW-1:0]  zero_cnt
);

   // S1 payload layout: {mode, d, t}
   localparam int W1 = 2 * N + 2;

   logic [N-1:0]  t_red;
   logic [W1-1:0] s1_data_in, s1_data;
   logic          s1_valid;
   logic          s2_ready;
   logic [N-1:0]  s1_t, s1_d;
   aoi_mode_e     s1_mode;
   logic [N-1:0]  s2_data_in;
   logic [CW-1:0] zero_cnt_q, zero_cnt_d;

   // Per-lane reduction across all operands: AND for mode[0]=0, OR for mode[0]=1.
   always_comb begin
      t_red = mode[0] ? '0 : '1;
      for (int k = 0; k < M; k++) begin
         if (mode[0]) t_red = t_red | ops[k*N +: N];
         else         t_red = t_red & ops[k*N +: N];
      end
      s1_data_in = {mode, d, t_red};
   end

   aoi_stage #(.W(W1)) u_s1 (
      .clk     (clk),
      .rst     (rst),
      .valid_i (in_valid),
      .data_i  (s1_data_in),
      .ready_o (in_ready),
      .valid_o (s1_valid),
      .data_o  (s1_data),
      .ready_i (s2_ready)
   );

   // Combine with d and apply the invert using the mode captured with this transaction.
   always_comb begin
      s1_t       = s1_data[N-1:0];
      s1_d       = s1_data[2*N-1:N];
      s1_mode    = aoi_mode_e'(s1_data[2*N+1:2*N]);
      s2_data_in = N'(aoi_eval(AOI_MAX_W'(s1_t), AOI_MAX_W'(s1_d), s1_mode));
   end

   aoi_stage #(.W(N)) u_s2 (
      .clk     (clk),
      .rst     (rst),
      .valid_i (s1_valid),
      .data_i  (s2_data_in),
      .ready_o (s2_ready),
      .valid_o (out_valid),
      .data_o  (y),
      .ready_i (out_ready)
   );

   // Count delivered zero results, holding at all-ones.
   always_comb begin
      zero_cnt_d = zero_cnt_q;
      if (out_valid && out_ready && (y == '0) && (zero_cnt_q != '1))
         zero_cnt_d = zero_cnt_q + 1'b1;
   end

   // Zero counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) zero_cnt_q <= '0;
      else     zero_cnt_q <= zero_cnt_d;
   end

   assign zero_cnt = zero_cnt_q;

endmodule

// File: tb/tb_aoi_pipe.sv
// Directed and randomized checks of aoi_pipe against a lane-counting reference model.
module tb_aoi_pipe;

   localparam int N  = 2;
   localparam int M  = 3;
   localparam int CW = 8;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic [M*N-1:0] ops;
   logic [N-1:0]   d;
   logic [1:0]     mode;
   logic           out_ready;
   logic           in_ready, out_valid;
   logic [N-1:0]   y;
   logic [CW-1:0]  zero_cnt;
   logic           in_ready2, out_valid2;
   logic [N-1:0]   y2;
   logic [1:0]     zero_cnt2;

   aoi_pipe #(.N(N), .M(M), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ops(ops), .d(d), .mode(mode), .out_valid(out_valid),
      .out_ready(out_ready), .y(y), .zero_cnt(zero_cnt)
   );

   aoi_pipe #(.N(N), .M(M), .CW(2)) dut_cw2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .ops(ops), .d(d), .mode(mode), .out_valid(out_valid2),
      .out_ready(out_ready), .y(y2), .zero_cnt(zero_cnt2)
   );

   // Clock and reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            tests_run = 0;
   int            tests_failed = 0;
   int            cyc = 0;
   int            accepts = 0;
   int            deliveries = 0;
   logic [N-1:0]  exp_q[$];
   int            acc_cyc_q[$];
   int            zc = 0;
   int            zc2 = 0;
   logic          s_ir, s_ov;
   logic [N-1:0]  s_y;
   logic          chk_lat = 1'b0;
   logic          rec_sat = 1'b0;
   logic          delivered_now;
   int            sat_seq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: per lane, count the operands with that bit set.
   function automatic logic [N-1:0] model(input logic [M*N-1:0] o, input logic [N-1:0] dd,
                                          input logic [1:0] md);
      logic [N-1:0] res;
      for (int lane = 0; lane < N; lane++) begin
         int  cnt;
         logic r, c;
         cnt = 0;
         for (int k = 0; k < M; k++) cnt += int'(o[k*N + lane]);
         r = md[0] ? (cnt > 0) : (cnt == M);
         c = md[0] ? (r && dd[lane]) : (r || dd[lane]);
         res[lane] = md[1] ? c : !c;
      end
      return res;
   endfunction

   // One clock: sample at negedge, score handshakes, advance past posedge.
   task automatic cycle();
      logic [N-1:0] e;
      int           a;
      @(negedge clk);
      s_ir = in_ready;
      s_ov = out_valid;
      s_y  = y;
      delivered_now = 1'b0;
      if (rst) begin
         exp_q.delete();
         acc_cyc_q.delete();
         zc  = 0;
         zc2 = 0;
      end else begin
         if (s_ov && out_ready) begin
            check("delivery_has_pending_tx", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               a = acc_cyc_q.pop_front();
               check("y", s_y, e);
               if (chk_lat) check("latency", cyc - a, 2);
               if (e == '0) begin
                  if (zc < 255) zc++;
                  if (zc2 < 3) zc2++;
               end
               deliveries++;
               delivered_now = 1'b1;
            end
         end
         if (in_valid && s_ir) begin
            exp_q.push_back(model(ops, d, mode));
            acc_cyc_q.push_back(cyc);
            accepts++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      check("zero_cnt", zero_cnt, zc);
      check("zero_cnt_cw2", zero_cnt2, zc2);
      if (rec_sat && delivered_now) sat_seq.push_back(int'(zero_cnt2));
   endtask

   // Driver: offer one transaction and hold it until accepted.
   task automatic send(input logic [M*N-1:0] o, input logic [N-1:0] dd, input logic [1:0] md);
      logic got;
      in_valid = 1'b1;
      ops = o;
      d = dd;
      mode = md;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         cycle();
         got = s_ir;
      end
      check("accept_within_bound", got, 1);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int acc0, del0;
      logic [N-1:0] held_y;
      int sat_exp[5];
      sat_exp = '{1, 2, 3, 3, 3};
      rst = 1'b1;
      in_valid = 1'b0;
      ops = '0;
      d = '0;
      mode = 2'b00;
      out_ready = 1'b0;

      // Reset state
      do_reset();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_y", y, 0);
      check("rst_zero_cnt", zero_cnt, 0);

      // AOI directed sequence with fixed latency
      out_ready = 1'b1;
      chk_lat = 1'b1;
      send(6'b00_00_00, 2'b00, 2'b00);
      send(6'b00_00_00, 2'b11, 2'b00);
      send(6'b11_11_11, 2'b00, 2'b00);
      drain();
      check("aoi_zero_cnt_final", zero_cnt, 2);

      // All four modes on ops {11,10,01}, d=10
      for (int m = 0; m < 4; m++) send(6'b11_10_01, 2'b10, 2'(m));
      drain();

      // Ten back-to-back transactions
      acc0 = accepts;
      del0 = deliveries;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         ops = 6'($urandom);
         d = 2'($urandom);
         mode = 2'($urandom);
         cycle();
         check("stream_in_ready", s_ir, 1);
      end
      in_valid = 1'b0;
      cycle();
      cycle();
      check("stream_accepts", accepts - acc0, 10);
      check("stream_deliveries_consecutive", deliveries - del0, 10);
      drain();
      chk_lat = 1'b0;

      // Backpressure: exactly two absorbed, output held stable
      out_ready = 1'b0;
      acc0 = accepts;
      in_valid = 1'b1;
      ops = 6'($urandom);
      d = 2'($urandom);
      mode = 2'($urandom);
      held_y = '0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (i == 2) begin
            check("bp_out_valid", s_ov, 1);
            held_y = s_y;
         end
         if (i > 2) begin
            check("bp_out_valid_hold", s_ov, 1);
            check("bp_y_stable", s_y, held_y);
         end
         if (s_ir) begin
            ops = 6'($urandom);
            d = 2'($urandom);
            mode = 2'($urandom);
         end
      end
      check("bp_accept_count", accepts - acc0, 2);
      check("bp_in_ready_low", s_ir, 0);
      out_ready = 1'b1;
      drain();

      // Randomized traffic with random backpressure
      in_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!in_valid || s_ir) begin
            in_valid = 1'($urandom_range(0, 1));
            ops = 6'($urandom);
            d = 2'($urandom);
            mode = 2'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      out_ready = 1'b1;
      drain();

      // Reset with both stages full
      out_ready = 1'b0;
      send(6'($urandom), 2'($urandom), 2'($urandom));
      send(6'($urandom), 2'($urandom), 2'($urandom));
      in_valid = 1'b0;
      cycle();
      check("full_before_reset", s_ir, 0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_y", y, 0);
      check("midrst_zero_cnt", zero_cnt, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("midrst_no_stale_delivery", s_ov, 0);
      end

      // Saturation of the 2-bit counter
      rec_sat = 1'b1;
      for (int i = 0; i < 5; i++) send(6'b00_00_00, 2'b00, 2'b10);
      drain();
      rec_sat = 1'b0;
      check("sat_seq_len", sat_seq.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < sat_seq.size()) check("sat_seq", sat_seq[i], sat_exp[i]);
      end
      check("sat_cw2_final", zero_cnt2, 3);
      check("sat_cw8_final", zero_cnt, 5);

      // Final report
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
